// File: rtl/nios_system_mem_tester.sv
// nios_system_mem_tester: Avalon-MM memory tester that fills a word range with an
// incrementing pattern, verifies it (error count / first failing address) or
// sums it. Checksum mode is compiled in only when MEM_TESTER_CHECKSUM_EN is defined;
// otherwise mode 10 is ignored like the reserved mode and checksum reads 0.
module nios_system_mem_tester #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic [DATA_W-1:0]   seed,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   checksum
);

    localparam logic [1:0] MODE_FILL   = 2'b00;
    localparam logic [1:0] MODE_VERIFY = 2'b01;
    localparam logic [1:0] MODE_CKSUM  = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [DATA_W-1:0] seed_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] idx_q;

    logic              mode_ok;
    logic              accept;
    logic              is_fill;
    logic              last_access;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_pattern;

    logic              rd_vld_p0;
    logic [DATA_W-1:0] exp_p0;
    logic [ADDR_W-1:0] addr_p0;

    // Error counter increment that sticks at all ones instead of wrapping
    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (&v) ? v : v + {{ADDR_W{1'b0}}, 1'b1};
    endfunction

`ifdef MEM_TESTER_CHECKSUM_EN
    assign mode_ok = (mode == MODE_FILL) || (mode == MODE_VERIFY) || (mode == MODE_CKSUM);
`else
    assign mode_ok = (mode == MODE_FILL) || (mode == MODE_VERIFY);
`endif

    assign accept      = (state_q == IDLE) && start && mode_ok;
    assign is_fill     = (mode_q == MODE_FILL);
    assign last_access = (idx_q == len_q - {{(ADDR_W-1){1'b0}}, 1'b1});
    assign cur_addr    = base_q + idx_q;
    assign cur_pattern = seed_q + DATA_W'(idx_q);

    assign m_clken = 1'b1;
    assign busy    = (state_q == ACCESS) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and Avalon master outputs; bus is idle outside ACCESS
    always_comb begin
        state_d      = state_q;
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_byteenable = '0;
        m_writedata  = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (length == '0) ? DONE : ACCESS;
            end
            ACCESS: begin
                m_chipselect = 1'b1;
                m_write      = is_fill;
                m_address    = cur_addr;
                m_byteenable = '1;
                m_writedata  = is_fill ? cur_pattern : '0;
                if (last_access) state_d = is_fill ? DONE : DRAIN;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, access index and verify results
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q          <= '0;
            rd_vld_p0      <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            mode_q         <= MODE_FILL;
        end else begin
            rd_vld_p0 <= (state_q == ACCESS) && !is_fill;
            if (accept) begin
                base_q         <= base_addr;
                len_q          <= length;
                seed_q         <= seed;
                mode_q         <= mode;
                idx_q          <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
            end else begin
                if (state_q == ACCESS) idx_q <= idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (rd_vld_p0 && (mode_q == MODE_VERIFY) && (m_readdata != exp_p0)) begin
                    err_count <= sat_inc(err_count);
                    if (err_count == '0) first_err_addr <= addr_p0;
                end
            end
        end
    end

    // ---- p0: expected word and address of the read issued this cycle ----
    // Read data returns one cycle later and is compared against these.
    always_ff @(posedge clk) begin
        exp_p0  <= cur_pattern;
        addr_p0 <= cur_addr;
    end

`ifdef MEM_TESTER_CHECKSUM_EN
    logic [DATA_W-1:0] cks_acc;

    // Running sum of returned read words in checksum mode
    always_ff @(posedge clk) begin
        if (reset) begin
            cks_acc <= '0;
        end else if (accept) begin
            cks_acc <= '0;
        end else if (rd_vld_p0 && (mode_q == MODE_CKSUM)) begin
            cks_acc <= cks_acc + m_readdata;
        end
    end

    assign checksum = cks_acc;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_nios_system_mem_tester.sv
// Directed bench for nios_system_mem_tester with a behavioural single-port memory.
module tb_nios_system_mem_tester;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic [31:0] seed;
    logic [15:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_clken;
    logic [31:0] m_readdata;
    logic        busy;
    logic        done;
    logic [16:0] err_count;
    logic [15:0] first_err_addr;
    logic [31:0] checksum;

    logic [31:0] mem [0:65535];
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [31:0] poke_data;

    int passed = 0;
    int total  = 0;

    nios_system_mem_tester #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Single-port memory: write on access, read data one cycle later
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (m_chipselect && m_write) mem[m_address] <= m_writedata;
        if (m_chipselect && !m_write) m_readdata <= mem[m_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    initial begin
        logic [15:0] wrap_addr [3];
        logic [31:0] wrap_data [3];
        int done_seen;
        wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000};
        wrap_data = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        reset = 1'b1; start = 1'b0; mode = 2'b00; base_addr = '0; length = '0; seed = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        tick(); tick();
        // reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", m_chipselect, 0);
        check("rst_wr", m_write, 0);
        check("rst_addr", m_address, 0);
        check("rst_be", m_byteenable, 0);
        check("rst_wd", m_writedata, 0);
        check("rst_clken", m_clken, 1);
        check("rst_err", err_count, 0);
        check("rst_fea", first_err_addr, 0);
        check("rst_cks", checksum, 0);
        reset = 1'b0;
        tick();

        // fill 0x0010..0x0013 with 0xA0000000..
        base_addr = 16'h0010; length = 16'd4; seed = 32'hA0000000; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fill_cs", m_chipselect, 1);
            check("fill_wr", m_write, 1);
            check("fill_be", m_byteenable, 4'hF);
            check("fill_busy", busy, 1);
            check("fill_addr", m_address, 16'h0010 + 16'(i));
            check("fill_wd", m_writedata, 32'hA0000000 + 32'(i));
            tick();
        end
        check("fill_done", done, 1);
        check("fill_done_busy", busy, 0);
        check("fill_done_cs", m_chipselect, 0);
        tick();
        check("fill_done_pulse", done, 0);
        check("fill_mem10", mem[16'h0010], 32'hA0000000);
        check("fill_mem13", mem[16'h0013], 32'hA0000003);

        // verify with word 0x0012 corrupted; start during busy and in DONE ignored
        poke(16'h0012, 32'h0);
        mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ver_cs", m_chipselect, 1);
            check("ver_wr", m_write, 0);
            check("ver_addr", m_address, 16'h0010 + 16'(i));
            start = (i == 1);
            mode = 2'b00; base_addr = 16'h0000; length = 16'd0;
            tick();
        end
        start = 1'b0;
        check("ver_drain_busy", busy, 1);
        check("ver_drain_done", done, 0);
        check("ver_drain_cs", m_chipselect, 0);
        tick();
        check("ver_done", done, 1);
        check("ver_err", err_count, 1);
        check("ver_fea", first_err_addr, 16'h0012);
        base_addr = 16'h0300; length = 16'd2; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_busy", busy, 0);
        check("done_start_cs", m_chipselect, 0);
        check("hold_err", err_count, 1);
        check("hold_fea", first_err_addr, 16'h0012);
        check("ver_mem12", mem[16'h0012], 32'h0);
        tick();

        // fill with address and data wrap
        base_addr = 16'hFFFE; length = 16'd3; seed = 32'hFFFFFFFF; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wrap_addr", m_address, wrap_addr[i]);
            check("wrap_wd", m_writedata, wrap_data[i]);
            tick();
        end
        check("wrap_done", done, 1);
        tick();

        // zero-length verify also clears previous results
        base_addr = 16'h0040; length = 16'd0; mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_cs", m_chipselect, 0);
        check("len0_busy", busy, 0);
        check("len0_err", err_count, 0);
        check("len0_fea", first_err_addr, 0);
        tick();

        // checksum over 1, 2, 0xFFFFFFFF
        poke(16'h0100, 32'h1);
        poke(16'h0101, 32'h2);
        poke(16'h0102, 32'hFFFFFFFF);
        base_addr = 16'h0100; length = 16'd3; mode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MEM_TESTER_CHECKSUM_EN
        for (int i = 0; i < 3; i++) begin
            check("cks_cs", m_chipselect, 1);
            check("cks_wr", m_write, 0);
            tick();
        end
        check("cks_drain", busy, 1);
        tick();
        check("cks_done", done, 1);
        check("cks_value", checksum, 32'h00000002);
`else
        check("cks_off_busy", busy, 0);
        check("cks_off_cs", m_chipselect, 0);
        tick();
        check("cks_off_busy2", busy, 0);
        check("cks_off_done", done, 0);
        check("cks_off_value", checksum, 0);
`endif
        tick();

        // reset during the third access of a length-8 fill
        base_addr = 16'h0200; length = 16'd8; seed = 32'h5; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_addr2", m_address, 16'h0201);
        tick();
        check("abort_cs3", m_chipselect, 1);
        check("abort_addr3", m_address, 16'h0202);
        reset = 1'b1;
        tick();
        check("abort_cs", m_chipselect, 0);
        check("abort_wr", m_write, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", m_address, 0);
        check("abort_wd", m_writedata, 0);
        check("abort_be", m_byteenable, 0);
        check("abort_clken", m_clken, 1);
        check("abort_err", err_count, 0);
        check("abort_fea", first_err_addr, 0);
        check("abort_cks", checksum, 0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || m_chipselect) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nios_system_mem_tester.md
NIOS_SYSTEM_MEM_TESTER -- requirements
Module: nios_system_mem_tester

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, word-address width of the target memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width of the target memory; byteenable width is DATA_W/8.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1: command strobe, sampled in IDLE only.
REQ-006 Port mode, input, 2: 00 = fill, 01 = verify, 10 = checksum, 11 = reserved.
REQ-007 Port base_addr, input, ADDR_W: first word address.
REQ-008 Port length, input, ADDR_W: word count; 0 means no accesses.
REQ-009 Port seed, input, DATA_W: pattern start value.
REQ-010 Ports m_address (ADDR_W), m_byteenable (DATA_W/8), m_chipselect (1), m_write (1), m_writedata (DATA_W), m_clken (1): outputs, Avalon-MM master side to the single-port on-chip memory slave.
REQ-011 Port m_readdata, input, DATA_W: slave read data, valid exactly one cycle after a read access.
REQ-012 Ports busy (1), done (1), err_count (ADDR_W+1), first_err_addr (ADDR_W), checksum (DATA_W): outputs, status/results.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS, DRAIN, DONE.
REQ-014 In IDLE, start=1 with mode 00/01/10 SHALL latch base_addr, length, seed, mode and clear err_count, first_err_addr, checksum; next state ACCESS (DONE if length=0).
REQ-015 start with mode 11, or start while not IDLE, SHALL be ignored.
REQ-016 ACCESS SHALL issue one access per cycle, index i = 0..length-1: m_chipselect=1, m_address=(base_addr+i) mod 2^ADDR_W, m_byteenable all ones.
REQ-017 Fill: m_write=1, m_writedata=seed+i mod 2^DATA_W; after last write, next state DONE.
REQ-018 Verify/checksum: m_write=0; after last read, next state DRAIN (one cycle, captures final read data), then DONE.
REQ-019 Read data arriving in cycle t SHALL be attributed to the address issued in cycle t-1.
REQ-020 Verify: each word != seed+i SHALL increment err_count (saturating at all ones); the first mismatching address SHALL load first_err_addr.
REQ-021 Checksum: checksum SHALL accumulate the sum of all read words mod 2^DATA_W.
REQ-022 DONE SHALL last one cycle with done=1, busy=0, then IDLE; start in DONE is ignored.
REQ-023 busy SHALL be 1 in ACCESS and DRAIN, else 0.
REQ-024 Latency: start accepted at edge k; first access in cycle k+1; done in cycle k+length+1 (fill) or k+length+2 (verify/checksum); length=0 gives done in cycle k+1.
REQ-025 Outside ACCESS, m_chipselect and m_write SHALL be 0; m_clken SHALL be 1 always.
REQ-026 Results SHALL hold their values from DONE until the next accepted start.

Reset
REQ-027 On reset, at the next edge: state IDLE; busy, done, m_chipselect, m_write = 0; m_address, m_writedata, err_count, first_err_addr, checksum = 0; m_byteenable = 0; m_clken = 1.
REQ-028 Reset mid-operation SHALL abort immediately; no access SHALL be issued in the cycle after the reset edge, and no done pulse SHALL occur.

Configuration
REQ-029 Macro MEM_TESTER_CHECKSUM_EN SHALL compile in checksum mode.
REQ-030 With MEM_TESTER_CHECKSUM_EN defined, mode 10 SHALL behave per REQ-018/021.
REQ-031 Without it, mode 10 SHALL be treated as reserved (ignored per REQ-015), the checksum output SHALL be constant 0, and no accumulator logic SHALL be synthesized.

Verification
REQ-032 Fill, base=0x0010, length=4, seed=0xA0000000 -> writes 0xA0000000..0xA0000003 at 0x0010..0x0013 in cycles k+1..k+4; done in cycle k+5.
REQ-033 Verify after REQ-032 with memory word 0x0012 corrupted to 0 -> err_count=1, first_err_addr=0x0012, done in cycle k+6.
REQ-034 Fill, base=0xFFFE, length=3, seed=0xFFFFFFFF -> addresses 0xFFFE, 0xFFFF, 0x0000; data 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-035 Checksum (macro defined) over words 1, 2, 0xFFFFFFFF -> checksum=0x00000002; macro undefined -> start ignored, busy stays 0, checksum=0.
REQ-036 length=0 -> no chipselect, done in cycle k+1; start asserted during busy -> ignored, results unaffected.
REQ-037 reset asserted in the 3rd ACCESS cycle of a length-8 fill -> no access in following cycle, all outputs per REQ-027, no done pulse.
